// File: rtl/sc_io_controller.sv
// sc_io_controller: memory-mapped I/O block for the single-cycle computer.
// Decodes a 256-byte I/O window, keeps stores out of data memory, supplies
// load data for the CPU load mux, synchronises switches/keys and latches
// key-press edges in sticky clear-on-read flags.
//
// Optional build macro: KEY_DEBOUNCE_EN adds a per-key stable-count filter
// (DEBOUNCE_CYCLES) between the key synchroniser and edge detection.
//
// Ports:
//   clock, resetn      clock (rising edge), synchronous active-low reset
//   addr, datain       CPU data address / store data
//   we, re             CPU store / load strobes
//   sw[9:0], key[3:0]  asynchronous board inputs (key active-low)
//   io_sel             addr lies in the I/O window (combinational)
//   dmem_we            store strobe for data memory (combinational)
//   io_rdata           read data for the addressed I/O register (combinational)
//   led[9:0]           LED register
//   hex5..hex0         active-low seven-segment glyphs {g,f,e,d,c,b,a}
module sc_io_controller #(
    parameter logic [31:0] IO_BASE = 32'h0000_FF00
`ifdef KEY_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    input  logic        re,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic        io_sel,
    output logic        dmem_we,
    output logic [31:0] io_rdata,
    output logic [9:0]  led,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned NUM_HEX  = 6;
    localparam int unsigned OFS_W    = 6;

    localparam logic [OFS_W-1:0] OFS_SW   = 6'd0;
    localparam logic [OFS_W-1:0] OFS_KEYS = 6'd1;
    localparam logic [OFS_W-1:0] OFS_EDGE = 6'd2;
    localparam logic [OFS_W-1:0] OFS_LED  = 6'd3;
    localparam logic [OFS_W-1:0] OFS_HEX0 = 6'd4;
    localparam logic [OFS_W-1:0] OFS_HEX5 = 6'd9;

    // Active-low glyph lookup; bit 4 blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [4:0] v);
        logic [6:0] s;
        case (v[3:0])
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return v[4] ? 7'h7F : s;
    endfunction

    logic [OFS_W-1:0]    offset;
    logic                wr_io;
    logic                edge_clr;
    logic [9:0]          sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] key_s1, key_s2, key_acc;
    logic [NUM_KEYS-1:0] pressed, pressed_q, edge_flags, armed, new_edges;
    logic [1:0]          settle_cnt;
    logic                settled;
    logic [4:0]          hex_val [NUM_HEX];
    logic [6:0]          hex_seg [NUM_HEX];
    logic                unused_bits;

    assign offset   = addr[7:2];
    assign io_sel   = (addr[31:8] == IO_BASE[31:8]);
    assign dmem_we  = we & ~io_sel;
    assign wr_io    = we & io_sel;
    assign edge_clr = re & io_sel & (offset == OFS_EDGE);
    assign unused_bits = ^{addr[1:0], datain[31:10]};

    // Two-flop synchronisers; keys reset to released.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_db;

    // Accept a new key level only after it has differed for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_db <= '1;
            for (int i = 0; i < int'(NUM_KEYS); i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign key_acc = key_db;
`else
    assign key_acc = key_s2;
`endif

    assign pressed   = ~key_acc;
    assign settled   = (settle_cnt == 2'd2);
    // A key only produces edges once it has been seen released after reset,
    // so a button held through reset release cannot raise a flag.
    assign new_edges = pressed & ~pressed_q & armed;

    // Edge detection and sticky flags; a same-cycle set overrides the clear.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pressed_q  <= '0;
            edge_flags <= '0;
            armed      <= '0;
            settle_cnt <= '0;
        end else begin
            if (!settled) settle_cnt <= settle_cnt + 2'd1;
            if (settled)  armed <= armed | key_s2;
            pressed_q  <= pressed;
            edge_flags <= (edge_clr ? '0 : edge_flags) | new_edges;
        end
    end

    // RW registers; glyphs are decoded at write time so outputs come from flops.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            led <= '0;
            for (int i = 0; i < int'(NUM_HEX); i++) begin
                hex_val[i] <= 5'h10;
                hex_seg[i] <= 7'h7F;
            end
        end else if (wr_io) begin
            if (offset == OFS_LED) led <= datain[9:0];
            for (int i = 0; i < int'(NUM_HEX); i++) begin
                if (offset == OFS_HEX0 + OFS_W'(i)) begin
                    hex_val[i] <= datain[4:0];
                    hex_seg[i] <= seg_decode(datain[4:0]);
                end
            end
        end
    end

    // Read mux; unmapped offsets and non-I/O addresses return zero.
    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            case (offset)
                OFS_SW:   io_rdata = 32'(sw_s2);
                OFS_KEYS: io_rdata = 32'(pressed);
                OFS_EDGE: io_rdata = 32'(edge_flags);
                OFS_LED:  io_rdata = 32'(led);
                default: begin
                    if (offset >= OFS_HEX0 && offset <= OFS_HEX5)
                        io_rdata = 32'(hex_val[3'(offset - OFS_HEX0)]);
                end
            endcase
        end
    end

    assign hex0 = hex_seg[0];
    assign hex1 = hex_seg[1];
    assign hex2 = hex_seg[2];
    assign hex3 = hex_seg[3];
    assign hex4 = hex_seg[4];
    assign hex5 = hex_seg[5];

endmodule
